// File: rtl/alu_multicycle.sv
// Iterative 8-bit ALU stage feeding the register-file write port.
// Optional MUL datapath enabled by defining ALU_MUL_EN.
module alu_multicycle #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    input  logic             START,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE,
    output logic             WRITEENABLE
);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic [CNTW-1:0]  load_cnt;
    logic [WIDTH-1:0] fin;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
`ifdef ALU_MUL_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
`ifdef ALU_MUL_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // Iteration count: one step per multiplier bit or per shift position.
    always_comb begin
        load_cnt = '0;
        unique case (SELECT)
`ifdef ALU_MUL_EN
            OP_MUL: load_cnt = CNTW'(WIDTH);
`endif
            OP_SLL, OP_SRA, OP_ROR: load_cnt = CNTW'(DATA2[2:0]);
            default: load_cnt = '0;
        endcase
    end

    always_comb begin
        fin = '0;
        unique case (op_q)
            OP_FWD: fin = a_q;
            OP_ADD: fin = a_q + b_q;
            OP_AND: fin = a_q & b_q;
            OP_OR:  fin = a_q | b_q;
`ifdef ALU_MUL_EN
            OP_MUL: fin = acc_q;
`else
            OP_MUL: fin = '0;
`endif
            default: fin = a_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
`ifdef ALU_MUL_EN
        acc_d   = acc_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    a_d     = DATA1;
                    b_d     = DATA2;
                    op_d    = SELECT;
                    cnt_d   = load_cnt;
`ifdef ALU_MUL_EN
                    acc_d   = '0;
`endif
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    unique case (op_q)
`ifdef ALU_MUL_EN
                        OP_MUL: begin
                            if (b_q[0]) acc_d = acc_q + a_q;
                            a_d = {a_q[WIDTH-2:0], 1'b0};
                            b_d = {1'b0, b_q[WIDTH-1:1]};
                        end
`endif
                        OP_SLL: a_d = {a_q[WIDTH-2:0], 1'b0};
                        OP_SRA: a_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                        OP_ROR: a_d = {a_q[0], a_q[WIDTH-1:1]};
                        default: a_d = a_q;
                    endcase
                end else begin
                    res_d   = fin;
                    zero_d  = (fin == '0);
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign RESULT      = res_q;
    assign ZERO        = zero_q;
    assign BUSY        = (state_q == S_EXEC);
    assign DONE        = (state_q == S_FIN);
    assign WRITEENABLE = (state_q == S_FIN);

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised self-checking bench for alu_multicycle.
// Builds with or without ALU_MUL_EN.
module tb_alu_multicycle;

    logic       CLK;
    logic       RESET;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [2:0] SELECT;
    logic       START;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       BUSY;
    logic       DONE;
    logic       WRITEENABLE;

    int tests_run = 0;
    int tests_failed = 0;

    alu_multicycle dut (
        .CLK(CLK),
        .RESET(RESET),
        .DATA1(DATA1),
        .DATA2(DATA2),
        .SELECT(SELECT),
        .START(START),
        .RESULT(RESULT),
        .ZERO(ZERO),
        .BUSY(BUSY),
        .DONE(DONE),
        .WRITEENABLE(WRITEENABLE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: plain arithmetic on the opcode meaning.
    function automatic logic [7:0] model_res(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [2:0] sel);
        logic [15:0] t;
        int sh;
        sh = int'(b % 8);
        case (sel)
            3'd0: return a;
            3'd1: return 8'((int'(a) + int'(b)) % 256);
            3'd2: return a & b;
            3'd3: return a | b;
`ifdef ALU_MUL_EN
            3'd4: return 8'((int'(a) * int'(b)) % 256);
`else
            3'd4: return 8'h00;
`endif
            3'd5: return 8'((int'(a) * (1 << sh)) % 256);
            3'd6: return 8'((int'($signed(a)) >>> sh) & 255);
            default: begin
                t = {a, a} >> sh;
                return t[7:0];
            end
        endcase
    endfunction

    // Edges from the accepting edge until DONE is visible.
    function automatic int model_lat(input logic [7:0] b,
                                     input logic [2:0] sel);
        case (sel)
`ifdef ALU_MUL_EN
            3'd4: return 9;
`endif
            3'd5, 3'd6, 3'd7: return int'(b % 8) + 1;
            default: return 1;
        endcase
    endfunction

    task automatic issue_op(input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] sel,
                            output logic [7:0] res, output logic z,
                            output int lat, output bit busy_ok,
                            output bit pulse_ok);
        @(negedge CLK);
        DATA1 = a;
        DATA2 = b;
        SELECT = sel;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        DATA1 = 8'($urandom);
        DATA2 = 8'($urandom);
        SELECT = 3'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!DONE && lat < 20) begin
            if (!BUSY) busy_ok = 1'b0;
            @(posedge CLK);
            #1;
            lat++;
        end
        res = RESULT;
        z = ZERO;
        pulse_ok = DONE && WRITEENABLE && !BUSY;
        @(posedge CLK);
        #1;
        if (DONE || WRITEENABLE || BUSY) pulse_ok = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        START = 1'b0;
        DATA1 = 8'h00;
        DATA2 = 8'h00;
        SELECT = 3'd0;
        repeat (3) @(posedge CLK);
        #1;
        tests_run++;
        if (RESULT !== 8'h00 || ZERO !== 1'b1 || BUSY !== 1'b0 ||
            DONE !== 1'b0 || WRITEENABLE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: got res=%h z=%b b=%b d=%b we=%b want 00 1 0 0 0",
                     RESULT, ZERO, BUSY, DONE, WRITEENABLE);
        end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] va [7];
        logic [7:0] vb [7];
        logic [2:0] vs [7];
        logic [7:0] ve [7];
        int         vl [7];
        int         n;
        logic [7:0] res;
        logic z;
        int lat;
        bit bok, pok;
        va[0] = 8'h7F; vb[0] = 8'h01; vs[0] = 3'd1; ve[0] = 8'h80; vl[0] = 1;
        va[1] = 8'h90; vb[1] = 8'h03; vs[1] = 3'd6; ve[1] = 8'hF2; vl[1] = 4;
        va[2] = 8'h81; vb[2] = 8'h01; vs[2] = 3'd7; ve[2] = 8'hC0; vl[2] = 2;
        va[3] = 8'hA5; vb[3] = 8'h00; vs[3] = 3'd5; ve[3] = 8'hA5; vl[3] = 1;
`ifdef ALU_MUL_EN
        va[4] = 8'h0D; vb[4] = 8'h0B; vs[4] = 3'd4; ve[4] = 8'h8F; vl[4] = 9;
        va[5] = 8'h10; vb[5] = 8'h10; vs[5] = 3'd4; ve[5] = 8'h00; vl[5] = 9;
        n = 6;
`else
        va[4] = 8'h0D; vb[4] = 8'h0B; vs[4] = 3'd4; ve[4] = 8'h00; vl[4] = 1;
        va[5] = 8'h5A; vb[5] = 8'h0F; vs[5] = 3'd2; ve[5] = 8'h0A; vl[5] = 1;
        n = 6;
`endif
        va[6] = 8'h00; vb[6] = 8'h00; vs[6] = 3'd0; ve[6] = 8'h00; vl[6] = 1;
        for (int i = 0; i < n; i++) begin
            issue_op(va[i], vb[i], vs[i], res, z, lat, bok, pok);
            tests_run++;
            if (res !== ve[i] || z !== (ve[i] == 8'h00)) begin
                tests_failed++;
                $display("FAIL directed%0d result: got %h z=%b want %h", i, res, z, ve[i]);
            end
            tests_run++;
            if (lat !== vl[i] || !bok || !pok) begin
                tests_failed++;
                $display("FAIL directed%0d timing: lat=%0d busy_ok=%b pulse_ok=%b want lat=%0d 1 1",
                         i, lat, bok, pok, vl[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, res, exp;
        logic [2:0] sel;
        logic z;
        int lat;
        bit bok, pok;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            sel = 3'($urandom);
            exp = model_res(a, b, sel);
            issue_op(a, b, sel, res, z, lat, bok, pok);
            tests_run++;
            if (res !== exp || z !== (exp == 8'h00) || lat !== model_lat(b, sel) ||
                !bok || !pok) begin
                tests_failed++;
                $display("FAIL random%0d op=%0d a=%h b=%h: got %h z=%b lat=%0d bok=%b pok=%b want %h lat=%0d",
                         i, sel, a, b, res, z, lat, bok, pok, exp, model_lat(b, sel));
            end
        end
    endtask

    task automatic long_op(output logic [7:0] a, output logic [7:0] b,
                           output logic [2:0] sel);
`ifdef ALU_MUL_EN
        a = 8'h0D; b = 8'h0B; sel = 3'd4;
`else
        a = 8'h0D; b = 8'h07; sel = 3'd5;
`endif
    endtask

    task automatic test_start_while_busy();
        logic [7:0] a, b, exp, seen;
        logic [2:0] sel;
        int pulses;
        long_op(a, b, sel);
        exp = model_res(a, b, sel);
        seen = 8'hXX;
        @(negedge CLK);
        DATA1 = a; DATA2 = b; SELECT = sel; START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        DATA1 = 8'h01; DATA2 = 8'h01; SELECT = 3'd1; START = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin pulses++; seen = RESULT; end
        end
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin pulses++; seen = RESULT; end
        end
        tests_run++;
        if (pulses !== 1 || seen !== exp) begin
            tests_failed++;
            $display("FAIL start_busy: pulses=%0d res=%h want 1 %h", pulses, seen, exp);
        end
        tests_run++;
        if (RESULT !== exp || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_busy_hold: res=%h busy=%b want %h 0", RESULT, BUSY, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a, b, res;
        logic [2:0] sel;
        logic z;
        int lat, pulses;
        bit bok, pok;
        long_op(a, b, sel);
        @(negedge CLK);
        DATA1 = a; DATA2 = b; SELECT = sel; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        tests_run++;
        if (RESULT !== 8'h00 || ZERO !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: res=%h z=%b b=%b d=%b want 00 1 0 0",
                     RESULT, ZERO, BUSY, DONE);
        end
        @(negedge CLK);
        RESET = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (DONE || WRITEENABLE || BUSY) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: activity=%0d want 0", pulses);
        end
        issue_op(8'h02, 8'h03, 3'd1, res, z, lat, bok, pok);
        tests_run++;
        if (res !== 8'h05 || z !== 1'b0 || lat !== 1 || !pok) begin
            tests_failed++;
            $display("FAIL reset_mid_add: res=%h z=%b lat=%0d pok=%b want 05 0 1 1",
                     res, z, lat, pok);
        end
    endtask

    task automatic test_back_to_back();
        int pulses, bad;
        @(negedge CLK);
        DATA1 = 8'h21; DATA2 = 8'h12; SELECT = 3'd1; START = 1'b1;
        pulses = 0;
        bad = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                pulses++;
                if (e % 3 != 1 || RESULT !== 8'h33) bad++;
            end
        end
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(posedge CLK);
        tests_run++;
        if (pulses !== 4 || bad !== 0) begin
            tests_failed++;
            $display("FAIL back_to_back: pulses=%0d bad=%0d want 4 0", pulses, bad);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execution stage directly downstream of the 8-register, 8-bit register file.
- Consumes the two register read ports as operands DATA1 and DATA2.
- Executes one operation per START, using an iterative datapath for multiply and shifts.
- Returns RESULT with a one-cycle WRITEENABLE pulse for the register-file write port; BUSY stalls the control unit.

Parameters:
- WIDTH, 8: operand and result width. Only 8 is supported; it is fixed by the register file.
- CNTW, 4: width of the iteration counter. It must hold values 0..8.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset. It is sampled on the rising edge of CLK.
- DATA1  input  8  operand A (register-file OUT1).
- DATA2  input  8  operand B or shift amount (register-file OUT2).
- SELECT  input  3  opcode: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SLL, 110 SRA, 111 ROR.
- START  input  1  request; sampled only in IDLE.
- RESULT  output  8  registered result; holds its value until the next completion.
- ZERO  output  1  registered; 1 when RESULT==0. Updates together with RESULT.
- BUSY  output  1  1 while in state EXEC.
- DONE  output  1  one-cycle completion pulse.
- WRITEENABLE  output  1  equals DONE; drives the register-file WRITE input.

Behaviour:
- States: IDLE, EXEC, FIN (encoding free). State output mapping:
  - IDLE: BUSY=0, DONE=0.
  - EXEC: BUSY=1.
  - FIN: DONE=WRITEENABLE=1, for exactly one cycle.
- Reset: RESET==0 at an edge gives state IDLE, RESULT=0, ZERO=1, BUSY=0, DONE=0, WRITEENABLE=0, internal registers cleared.
  - Reset has priority over everything else.
  - Reset mid-EXEC discards the operation; no WRITEENABLE pulse is produced.
- IDLE, START=1 at edge e0:
  - Latch A=DATA1, B=DATA2, OP=SELECT, ACC=0.
  - Load CNT=N: 0 for FWD/ADD/AND/OR; 8 for MUL; DATA2[2:0] for SLL/SRA/ROR.
  - Go to EXEC.
  - After e0, DATA1, DATA2 and SELECT are don't-care until completion.
- EXEC, each edge:
  - CNT!=0: perform one step, CNT-=1.
  - CNT==0: load RESULT/ZERO, go to FIN.
- Step and final rules:
  - FWD: RESULT=A.
  - ADD: RESULT=(A+B) mod 256; carry is discarded.
  - AND: RESULT=A&B. OR: RESULT=A|B.
  - MUL step: if B[0], ACC=ACC+A (mod 256); then A=A<<1, B=B>>1 (logical). Final RESULT=ACC, i.e. the low 8 bits of the product.
  - SLL step: A=A<<1, zero fill. SRA step: A={A[7],A[7:1]}. ROR step: A={A[0],A[7:1]}. Final RESULT=A.
  - Shift amount 0: RESULT=DATA1 unchanged.
- Latency:
  - RESULT is valid and DONE=1 in the cycle after edge e0+1+N.
  - FIN lasts one cycle, then the next edge returns to IDLE.
  - This gives 1 cycle for logic ops, 9 for MUL, and 1..8 for shifts.
- Back-to-back: START seen in IDLE is accepted, so minimum issue spacing is N+3 cycles.
- START in EXEC or FIN is ignored; the requester must hold or re-assert START until BUSY/DONE are observed.
- Outputs are registered with no combinational path from inputs. The register file adds its own 2 ns read delay upstream; the operand-to-START setup time is the issuer's responsibility.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL is implemented as specified above.
- Undefined:
  - No MUL datapath or ACC adder is synthesised.
  - SELECT=100 is treated as an illegal opcode: N=0, RESULT=8'h00, ZERO=1, DONE/WRITEENABLE pulse as normal.
  - All other opcodes are unaffected.

Test Plan:
- ADD:
  - Stimulus: DATA1=0x7F, DATA2=0x01, SELECT=001, START at e0.
  - Response: BUSY=1 for one cycle; after e1, RESULT=0x80, ZERO=0, DONE=WRITEENABLE=1 for exactly one cycle.
- MUL (ALU_MUL_EN defined):
  - 0x0D*0x0B: RESULT=0x8F, DONE after e9, BUSY high for 9 cycles.
  - 0x10*0x10: RESULT=0x00, ZERO=1.
- Shifts:
  - SRA 0x90 by 3: RESULT=0xF2, DONE after e4.
  - ROR 0x81 by 1: RESULT=0xC0.
  - SLL 0xA5 by 0: RESULT=0xA5, DONE after e1.
- START while BUSY:
  - Stimulus: MUL started; second START with SELECT=001 asserted during EXEC.
  - Response: second request ignored; single DONE pulse carrying the MUL result; RESULT unchanged afterwards.
- Reset mid-operation:
  - Stimulus: RESET=0 at e4 of a MUL.
  - Response: next cycle RESULT=0, ZERO=1, BUSY=0, no DONE pulse. A new ADD 0x02+0x03 is accepted and yields 0x05.
- ALU_MUL_EN undefined:
  - Stimulus: SELECT=100, DATA1=0x0D, DATA2=0x0B.
  - Response: RESULT=0x00, ZERO=1, DONE after e1.
